pc_exc_sequencer: RTL and testbench
===================================

// Module: pc_exc_sequencer
// PURPOSE
//  Parametrised next-PC/exception sequencer for the single-cycle MIPS core: owns the PC register and selects seq/branch/jump/jr/vector/eret.
//  Generalises the fixed 3-source exception path to NUM_EXP prioritised channels with nested, pre-emptive service via an EPC stack.
//  Sits between ctr_unit/alu (decoded flow controls) and instruction_memory (pc output).
// PARAMETERS
//  ADDR_W      32            PC width (>=28); pc[1:0] always 0
//  NUM_EXP     3             exception channels; channel 0 = highest priority
//  STACK_DEPTH 4             EPC stack entries (max nesting depth)
//  VEC_BASE    32'h0000_0800 vector of channel 0
//  VEC_STRIDE  32'h0000_0010 vector(k) = VEC_BASE + k*VEC_STRIDE, truncated to ADDR_W
// PORTS
//  pc_clk      in  1             clock; all state updates on rising edge
//  reset       in  1             asynchronous, active-high
//  stall       in  1             1 = freeze pc, stack, pending (syscall halt)
//  branch      in  1             conditional branch instruction
//  bneorbeq    in  1             1 = beq, 0 = bne
//  equal       in  1             ALU equality flag
//  jump        in  1             j/jal
//  isjr        in  1             jr
//  iseret      in  1             eret (already qualified by iscop0)
//  imm_ext     in  ADDR_W        extended 16-bit immediate
//  jidx        in  26            instr[25:0]
//  jr_target   in  ADDR_W        rs value
//  exp_req     in  NUM_EXP       level exception requests
//  exp_mask    in  NUM_EXP       1 = channel masked
//  pc          out ADDR_W        current PC
//  pc_plus4    out ADDR_W        pc+4 (jal link value)
//  exp_ack     out NUM_EXP       one-hot, 1-cycle pulse when channel accepted
//  in_service  out NUM_EXP       one-hot channel at stack top; 0 when stack empty
//  nest_level  out clog2(STACK_DEPTH+1)  stack occupancy
//  eret_err    out 1             1-cycle pulse: eret with empty stack
// BEHAVIOUR
//  Reset (async): pc=0, stack empty, pending=0, exp_ack=0, in_service=0, nest_level=0, eret_err=0.
//  pending[k] set when exp_req[k]=1; cleared only on accept of k (latched; a 1-cycle request is not lost).
//  Candidate = lowest k with pending[k] & ~exp_mask[k]. Accepted iff stack not full, stall=0, iseret=0,
//   and (stack empty or k < channel at stack top). Otherwise stays pending.
//  Normal next PC (nseq), priority jr > jump > taken branch > seq:
//   seq pc+4; branch taken = branch & (bneorbeq ? equal : ~equal) -> pc+4+(imm_ext<<2);
//   jump -> {pc_plus4[ADDR_W-1:28], jidx, 2'b00}; jr -> jr_target & ~3.
//  Cycle priority: stall > eret > exception accept > nseq.
//   eret, stack non-empty: pc <= top.epc; pop; in_service <= new top channel.
//   eret, stack empty: pc <= pc+4; eret_err pulse; no other change.
//   accept k: push {epc=nseq, chan=k}; pc <= vector(k); exp_ack[k]=1 same cycle (combinational, registered
//    state next edge); current instruction still retires, so its return point is nseq.
//  eret and pending candidate in same cycle: eret wins; candidate re-evaluated next cycle vs. popped level.
//  Stack full: higher-priority requests stay pending until an eret pops.
//  stall=1: all registers hold; exp_ack=0; pending still sets from exp_req.
//  Reset mid-service: stack and pending discarded.
// CONFIGURATION
//  EXP_STATS_EN defined: adds output exp_cnt [NUM_EXP*8-1:0], per-channel 8-bit saturating accept counters
//   (channel k at [8k+7:8k]), reset to 0, +1 per exp_ack[k], hold at 255.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package pc_seq_pkg: next-PC select enum (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_VEC, SEL_ERET),
//   EPC stack entry typedef {epc, chan}, default VEC_BASE/VEC_STRIDE constants.
//  Sub-module epc_stack (DEPTH, entry width): push/pop/top/full/empty/count, async reset; no push+pop same cycle.
// TESTING
//  1 reset with pc=0x40 mid-run -> pc=0, nest_level=0, in_service=0 immediately.
//  2 pc=0x100, beq equal=1 imm_ext=3 -> pc=0x110; bne equal=1 -> 0x104; jr_target=0x207 -> 0x204.
//  3 pc=0x100, 1-cycle pulse exp_req[2] -> exp_ack[2], pc=0x820, nest_level=1; eret -> pc=0x104, level 0.
//  4 in service ch2, raise ch0 and ch2 -> ch0 accepted (pc=0x800, level 2); ch2 held until both erets.
//  5 in service ch0, raise ch1 -> no accept; eret -> ch1 accepted next cycle; eret with empty stack -> eret_err, pc+4.
//  6 STACK_DEPTH=2 full, higher request pending; stall=1 with jump -> pc holds; EXP_STATS_EN: 300 acks ch1 -> exp_cnt=255.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC / exception sequencer.
//   pc_sel_e        : next-PC source select
//   epc_entry_t     : EPC stack entry layout {epc, chan} at default widths
//   DEF_VEC_BASE    : default vector address of channel 0
//   DEF_VEC_STRIDE  : default spacing between channel vectors
//   chan_width()    : bits needed to index a channel number
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_VEC,
        SEL_ERET
    } pc_sel_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0800;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    typedef struct packed {
        logic [31:0] epc;
        logic [7:0]  chan;
    } epc_entry_t;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/epc_stack.sv
// LIFO holding return PC and channel for each nested exception.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (empties the stack)
//   push, din  : push din when not full
//   pop        : discard top entry when not empty (never together with push)
//   top        : current top entry ('0 when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries
module epc_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0] mem [DEPTH];

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count) begin
                    mem[i] <= din;
                end
            end
        end
    end

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == count) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_exc_sequencer.sv
// Next-PC / exception sequencer for the single-cycle MIPS core. Owns the PC,
// picks seq/branch/jump/jr/vector/eret, and services NUM_EXP prioritised
// exception channels (0 = highest) with pre-emptive nesting via an EPC stack.
// Ports:
//   pc_clk, reset     : clock, asynchronous active-high reset
//   stall             : freeze pc, stack and service state (pending still latches)
//   branch, bneorbeq, equal, jump, isjr, iseret : decoded flow controls
//   imm_ext, jidx, jr_target : branch offset, jump index, jr register value
//   exp_req, exp_mask : level requests, per-channel mask (1 = masked)
//   pc, pc_plus4      : current PC and link value
//   exp_ack           : one-hot accept pulse (combinational, same cycle)
//   in_service        : one-hot channel at stack top
//   nest_level        : stack occupancy
//   eret_err          : eret with nothing to return to
// Build option: define EXP_STATS_EN to add exp_cnt, per-channel 8-bit
// saturating accept counters (channel k at [8k+7:8k]).
module pc_exc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                NUM_EXP     = 3,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(DEF_VEC_BASE),
    parameter logic [ADDR_W-1:0] VEC_STRIDE  = ADDR_W'(DEF_VEC_STRIDE)
) (
    input  logic                             pc_clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch,
    input  logic                             bneorbeq,
    input  logic                             equal,
    input  logic                             jump,
    input  logic                             isjr,
    input  logic                             iseret,
    input  logic [ADDR_W-1:0]                imm_ext,
    input  logic [25:0]                      jidx,
    input  logic [ADDR_W-1:0]                jr_target,
    input  logic [NUM_EXP-1:0]               exp_req,
    input  logic [NUM_EXP-1:0]               exp_mask,
    output logic [ADDR_W-1:0]                pc,
    output logic [ADDR_W-1:0]                pc_plus4,
    output logic [NUM_EXP-1:0]               exp_ack,
    output logic [NUM_EXP-1:0]               in_service,
    output logic [$clog2(STACK_DEPTH+1)-1:0] nest_level,
    output logic                             eret_err
`ifdef EXP_STATS_EN
    ,
    output logic [NUM_EXP*8-1:0]             exp_cnt
`endif
);

    localparam int CHAN_W = chan_width(NUM_EXP);

    // Same {epc, chan} layout as epc_entry_t, sized to this instance.
    typedef struct packed {
        logic [ADDR_W-1:0] epc;
        logic [CHAN_W-1:0] chan;
    } entry_t;

    logic [ADDR_W-1:0]  br_target, j_target, jr_aligned, vec_addr, nseq, pc_next;
    logic               taken, pc_en, accept, push, pop;
    pc_sel_e            nseq_sel, sel;
    logic [NUM_EXP-1:0] pending, eligible;
    logic               cand_valid;
    logic [CHAN_W-1:0]  cand_idx;
    entry_t             push_entry, top_entry;
    logic               st_full, st_empty;

    // ---------------- next sequential/flow target ----------------
    assign pc_plus4   = pc + ADDR_W'(4);
    assign taken      = branch & (bneorbeq ? equal : ~equal);
    assign br_target  = pc_plus4 + (imm_ext << 2);
    assign jr_aligned = {jr_target[ADDR_W-1:2], 2'b00};

    if (ADDR_W > 28) begin : g_jseg
        assign j_target = {pc_plus4[ADDR_W-1:28], jidx, 2'b00};
    end else begin : g_jflat
        assign j_target = {jidx, 2'b00};
    end

    always_comb begin
        nseq_sel = SEL_SEQ;
        if (isjr) begin
            nseq_sel = SEL_JR;
        end else if (jump) begin
            nseq_sel = SEL_J;
        end else if (taken) begin
            nseq_sel = SEL_BR;
        end
    end

    always_comb begin
        case (nseq_sel)
            SEL_JR:  nseq = jr_aligned;
            SEL_J:   nseq = j_target;
            SEL_BR:  nseq = br_target;
            default: nseq = pc_plus4;
        endcase
    end

    // ---------------- exception candidate ----------------
    assign eligible = pending & ~exp_mask;

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_EXP; i++) begin
            if (!cand_valid && eligible[i]) begin
                cand_valid = 1'b1;
                cand_idx   = CHAN_W'(i);
            end
        end
    end

    assign vec_addr = VEC_BASE + VEC_STRIDE * ADDR_W'(cand_idx);

    // ---------------- cycle arbitration: stall > eret > accept > nseq ----------------
    always_comb begin
        pc_en    = 1'b1;
        sel      = nseq_sel;
        accept   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        eret_err = 1'b0;
        if (stall) begin
            pc_en = 1'b0;
        end else if (iseret) begin
            if (!st_empty) begin
                sel = SEL_ERET;
                pop = 1'b1;
            end else begin
                sel      = SEL_SEQ;
                eret_err = !reset;
            end
        end else if (cand_valid && !st_full &&
                     (st_empty || cand_idx < top_entry.chan)) begin
            sel    = SEL_VEC;
            accept = 1'b1;
            push   = 1'b1;
        end
    end

    always_comb begin
        case (sel)
            SEL_ERET: pc_next = top_entry.epc;
            SEL_VEC:  pc_next = vec_addr;
            SEL_JR:   pc_next = jr_aligned;
            SEL_J:    pc_next = j_target;
            SEL_BR:   pc_next = br_target;
            default:  pc_next = pc_plus4;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_EXP; i++) begin
            exp_ack[i]    = accept && (cand_idx == CHAN_W'(i));
            in_service[i] = !st_empty && (top_entry.chan == CHAN_W'(i));
        end
    end

    // The interrupted instruction still retires, so its return point is nseq.
    assign push_entry = '{epc: nseq, chan: cand_idx};

    // ---------------- state ----------------
    always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | exp_req) & ~exp_ack;
        end
    end

    epc_stack #(
        .DEPTH (STACK_DEPTH),
        .W     ($bits(entry_t))
    ) u_stack (
        .clk   (pc_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .top   (top_entry),
        .full  (st_full),
        .empty (st_empty),
        .count (nest_level)
    );

`ifdef EXP_STATS_EN
    logic [7:0] cnt [NUM_EXP];

    always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_EXP; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_EXP; k++) begin
                if (exp_ack[k] && cnt[k] != '1) begin
                    cnt[k] <= cnt[k] + 8'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_EXP; k++) begin : g_cnt
        assign exp_cnt[8*k +: 8] = cnt[k];
    end
`endif

endmodule

// File: tb/tb_pc_exc_sequencer.sv
// Self-checking bench for pc_exc_sequencer (NUM_EXP=3, STACK_DEPTH=2).
// Table-driven next-PC vectors plus hand-written nesting/eret/stall sequences;
// expectations are queued and compared when the DUT output is sampled.
module tb_pc_exc_sequencer;

    localparam int ADDR_W = 32;
    localparam int NUM_EXP = 3;
    localparam int DEPTH = 2;
    localparam int NL_W = $clog2(DEPTH + 1);

    logic              pc_clk = 1'b0;
    logic              reset, stall, branch, bneorbeq, equal, jump, isjr, iseret;
    logic [ADDR_W-1:0] imm_ext, jr_target;
    logic [25:0]       jidx;
    logic [2:0]        exp_req, exp_mask;
    logic [ADDR_W-1:0] pc, pc_plus4;
    logic [2:0]        exp_ack, in_service;
    logic [NL_W-1:0]   nest_level;
    logic              eret_err;
`ifdef EXP_STATS_EN
    logic [NUM_EXP*8-1:0] exp_cnt;
`endif

    always #5 pc_clk = ~pc_clk;

    pc_exc_sequencer #(
        .ADDR_W      (ADDR_W),
        .NUM_EXP     (NUM_EXP),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .pc_clk     (pc_clk),
        .reset      (reset),
        .stall      (stall),
        .branch     (branch),
        .bneorbeq   (bneorbeq),
        .equal      (equal),
        .jump       (jump),
        .isjr       (isjr),
        .iseret     (iseret),
        .imm_ext    (imm_ext),
        .jidx       (jidx),
        .jr_target  (jr_target),
        .exp_req    (exp_req),
        .exp_mask   (exp_mask),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .exp_ack    (exp_ack),
        .in_service (in_service),
        .nest_level (nest_level),
        .eret_err   (eret_err)
`ifdef EXP_STATS_EN
        ,
        .exp_cnt    (exp_cnt)
`endif
    );

    typedef enum int {S_PC, S_PC4, S_NEST, S_INSV, S_ACK, S_ERR, S_CNT1} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_PC:   return pc;
            S_PC4:  return pc_plus4;
            S_NEST: return 32'(nest_level);
            S_INSV: return 32'(in_service);
            S_ACK:  return 32'(exp_ack);
            S_ERR:  return 32'(eret_err);
`ifdef EXP_STATS_EN
            S_CNT1: return 32'(exp_cnt[15:8]);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp(input string name, input sig_e sig, input logic [31:0] val);
        sb.push_back('{name, sig, val});
    endtask

    task automatic drain();
        sb_t it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            act = observe(it.sig);
            n_vec++;
            if (act !== it.val) begin
                n_err++;
                $display("FAIL %s: got %h, want %h (t=%0t)", it.name, act, it.val, $time);
            end
        end
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic tick();
        @(posedge pc_clk);
        #1;
        drain();
    endtask

    task automatic clr();
        stall = 0; branch = 0; bneorbeq = 0; equal = 0; jump = 0; isjr = 0; iseret = 0;
        imm_ext = '0; jidx = '0; jr_target = '0; exp_req = '0; exp_mask = '0;
    endtask

    task automatic set_pc(input logic [31:0] a, input logic [2:0] req);
        isjr = 1; jr_target = a; exp_req = req;
        tick();
        isjr = 0; jr_target = '0; exp_req = '0;
    endtask

    // state checks after an edge
    task automatic st(input string n, input logic [31:0] p, input int lvl, input logic [2:0] insv);
        exp({n, ".pc"}, S_PC, p);
        exp({n, ".nest"}, S_NEST, 32'(lvl));
        exp({n, ".insv"}, S_INSV, 32'(insv));
    endtask

    typedef struct {
        logic [31:0] start;
        logic        br, beq, eq, j, jr;
        logic [31:0] imm;
        logic [25:0] idx;
        logic [31:0] jrt;
        logic [31:0] want;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0, 32'h110};
        vt[1]  = '{32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0, 32'h104};
        vt[2]  = '{32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0, 32'h110};
        vt[3]  = '{32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0, 32'h104};
        vt[4]  = '{32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'h0, 32'h207, 32'h204};
        vt[5]  = '{32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 26'h123, 32'h0, 32'h48C};
        vt[6]  = '{32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 26'h10, 32'h0, 32'hF000_0040};
        vt[7]  = '{32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 26'h80, 32'h300, 32'h300};
        vt[8]  = '{32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 26'h80, 32'h0, 32'h200};
        vt[9]  = '{32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'hFC};
        vt[10] = '{32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'h0, 32'h0, 32'h104};
        vt[11] = '{32'h0FFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 26'h1, 32'h0, 32'h1000_0004};

        clr();
        reset = 1;
        #12;
        exp("rst.pc", S_PC, 32'h0);
        exp("rst.nest", S_NEST, 32'h0);
        exp("rst.insv", S_INSV, 32'h0);
        exp("rst.ack", S_ACK, 32'h0);
        exp("rst.err", S_ERR, 32'h0);
        settle();
        reset = 0;
        exp("first.pc", S_PC, 32'h4);
        tick();

        // ---- next-PC table ----
        for (int i = 0; i < 12; i++) begin
            set_pc(vt[i].start, 3'b000);
            branch = vt[i].br; bneorbeq = vt[i].beq; equal = vt[i].eq;
            jump = vt[i].j; isjr = vt[i].jr; imm_ext = vt[i].imm;
            jidx = vt[i].idx; jr_target = vt[i].jrt;
            exp($sformatf("vec%0d.start", i), S_PC, vt[i].start);
            exp($sformatf("vec%0d.pc4", i), S_PC4, vt[i].start + 32'd4);
            settle();
            exp($sformatf("vec%0d.next", i), S_PC, vt[i].want);
            tick();
            clr();
        end

        // ---- single exception, eret ----
        set_pc(32'h100, 3'b100);
        exp("t3.ack", S_ACK, 32'b100);
        exp("t3.pc", S_PC, 32'h100);
        settle();
        st("t3.vec", 32'h820, 1, 3'b100);
        tick();
        exp("t3.ack_low", S_ACK, 32'h0);
        settle();

        // ---- pre-emption by ch0, ch2 held ----
        exp_req = 3'b101;
        exp("t4.seq", S_PC, 32'h824);
        tick();
        exp_req = '0;
        exp("t4.ack0", S_ACK, 32'b001);
        settle();
        st("t4.nest", 32'h800, 2, 3'b001);
        tick();
        exp("t4.hold2", S_ACK, 32'h0);
        settle();
        exp("t4.run", S_PC, 32'h804);
        tick();
        iseret = 1;
        exp("t4.eret_ack", S_ACK, 32'h0);
        exp("t4.eret_err", S_ERR, 32'h0);
        settle();
        st("t4.pop1", 32'h828, 1, 3'b100);
        tick();
        iseret = 0;
        exp("t4.same_ch", S_ACK, 32'h0);
        settle();
        exp("t4.run2", S_PC, 32'h82C);
        tick();
        iseret = 1;
        st("t4.pop2", 32'h104, 0, 3'b000);
        tick();
        iseret = 0;
        exp("t4.ack2", S_ACK, 32'b100);
        settle();
        st("t4.vec2", 32'h820, 1, 3'b100);
        tick();

        // ---- stack full, stall, eret-wins ----
        exp_req = 3'b010;
        exp("t6.seq", S_PC, 32'h824);
        tick();
        exp_req = '0;
        exp("t6.ack1", S_ACK, 32'b010);
        settle();
        st("t6.full", 32'h810, 2, 3'b010);
        tick();
        exp_req = 3'b001;
        exp("t6.run", S_PC, 32'h814);
        tick();
        exp_req = '0;
        exp("t6.full_hold", S_ACK, 32'h0);
        settle();
        st("t6.full_run", 32'h818, 2, 3'b010);
        tick();
        stall = 1; jump = 1; jidx = 26'h100;
        exp("t6.stall_ack", S_ACK, 32'h0);
        settle();
        st("t6.stall", 32'h818, 2, 3'b010);
        tick();
        stall = 0; jump = 0; jidx = '0;
        iseret = 1;
        exp("t6.eret_wins", S_ACK, 32'h0);
        settle();
        st("t6.pop", 32'h828, 1, 3'b100);
        tick();
        iseret = 0;
        exp("t6.ack0", S_ACK, 32'b001);
        settle();
        st("t6.vec0", 32'h800, 2, 3'b001);
        tick();
        iseret = 1;
        st("t6.pop_a", 32'h82C, 1, 3'b100);
        tick();
        st("t6.pop_b", 32'h108, 0, 3'b000);
        tick();
        iseret = 0;

        // ---- mask, lower priority blocked, eret empty ----
        exp_mask = 3'b001; exp_req = 3'b001;
        exp("t5.seq", S_PC, 32'h10C);
        tick();
        exp_req = '0;
        exp("t5.masked", S_ACK, 32'h0);
        settle();
        exp("t5.seq2", S_PC, 32'h110);
        tick();
        exp_mask = '0;
        exp("t5.unmask", S_ACK, 32'b001);
        settle();
        st("t5.vec0", 32'h800, 1, 3'b001);
        tick();
        exp_req = 3'b010;
        tick();
        exp_req = '0;
        exp("t5.no_accept", S_ACK, 32'h0);
        settle();
        exp("t5.run", S_PC, 32'h808);
        tick();
        iseret = 1;
        exp("t5.eret_first", S_ACK, 32'h0);
        settle();
        st("t5.pop", 32'h114, 0, 3'b000);
        tick();
        iseret = 0;
        exp("t5.ack1", S_ACK, 32'b010);
        settle();
        st("t5.vec1", 32'h810, 1, 3'b010);
        tick();
        iseret = 1;
        st("t5.pop1", 32'h118, 0, 3'b000);
        tick();
        exp("t5.eret_err", S_ERR, 32'h1);
        exp("t5.err_noack", S_ACK, 32'h0);
        settle();
        st("t5.err_pc", 32'h11C, 0, 3'b000);
        tick();
        iseret = 0;
        exp("t5.err_low", S_ERR, 32'h0);
        settle();

        // ---- pending latches during stall ----
        stall = 1; exp_req = 3'b100;
        exp("stl.hold", S_PC, 32'h11C);
        tick();
        exp_req = '0;
        exp("stl.noack", S_ACK, 32'h0);
        settle();
        exp("stl.hold2", S_PC, 32'h11C);
        tick();
        stall = 0;
        exp("stl.ack", S_ACK, 32'b100);
        settle();
        st("stl.vec", 32'h820, 1, 3'b100);
        tick();

        // ---- asynchronous reset mid-service ----
        set_pc(32'h40, 3'b001);
        exp("t1.pc40", S_PC, 32'h40);
        exp("t1.nest1", S_NEST, 32'h1);
        settle();
        reset = 1;
        st("t1.rst", 32'h0, 0, 3'b000);
        exp("t1.rst_ack", S_ACK, 32'h0);
        settle();
        tick();
        reset = 0;
        exp("t1.pend_gone", S_ACK, 32'h0);
        settle();
        st("t1.after", 32'h4, 0, 3'b000);
        tick();

`ifdef EXP_STATS_EN
        reset = 1;
        #2;
        reset = 0;
        exp("cnt.rst", S_CNT1, 32'h0);
        settle();
        exp_req = 3'b010;
        tick();
        for (int n = 1; n <= 300; n++) begin
            iseret = 0;
            tick();
            iseret = 1;
            tick();
            if (n == 10) begin
                exp("cnt.10", S_CNT1, 32'd10);
                settle();
            end
        end
        exp("cnt.sat", S_CNT1, 32'd255);
        settle();
        clr();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
